// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the multi-cycle arithmetic blocks.
package alu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sub_state_t;

    function automatic int chunk_count(input int bits_width, input int chunk_width);
        return bits_width / chunk_width;
    endfunction

endpackage

// File: rtl/sub_chunk.sv
// sub_chunk: combinational CHUNK_WIDTH-bit adder with carry in/out.
module sub_chunk #(
    parameter int CHUNK_WIDTH = 1
) (
    input  logic [CHUNK_WIDTH-1:0] x,
    input  logic [CHUNK_WIDTH-1:0] y,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] s,
    output logic                   cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y} + {{CHUNK_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b, CHUNK_WIDTH bits per cycle, LSB chunk first, valid/ready on both sides.
// Define SUB_ZERO_FLAG_EN to add the out_zero port, OR-accumulated over the result chunks.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int BITS_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS_WIDTH-1:0] a,
    input  logic [BITS_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS_WIDTH-1:0] out_d,
    output logic                  out_b,
    output logic                  overflow
`ifdef SUB_ZERO_FLAG_EN
    ,
    output logic                  out_zero
`endif
);

    localparam int N     = chunk_count(BITS_WIDTH, CHUNK_WIDTH);
    localparam int CNT_W = $clog2(N) + 1;
    localparam int MSB   = BITS_WIDTH - 1;

    if (BITS_WIDTH < 2 || BITS_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_cfg
        $error("serial_subtractor: BITS_WIDTH must be >= 2 and a multiple of CHUNK_WIDTH");
    end

    sub_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [MSB:0]     a_q, a_d, nb_q, nb_d, d_q, d_d, s_ext;
    logic             carry_q, carry_d, sa_q, sa_d, sb_q, sb_d, b_q, b_d, ov_q, ov_d;
    logic [CHUNK_WIDTH-1:0] s;
    logic             cout;
`ifdef SUB_ZERO_FLAG_EN
    logic             nz_q, nz_d, z_q, z_d;
    assign out_zero = z_q;
`endif

    sub_chunk #(.CHUNK_WIDTH(CHUNK_WIDTH)) u_chunk (
        .x    (a_q[CHUNK_WIDTH-1:0]),
        .y    (nb_q[CHUNK_WIDTH-1:0]),
        .cin  (carry_q),
        .s    (s),
        .cout (cout)
    );

    // Result chunks enter the minuend register from the top as its bits are consumed from the bottom.
    assign s_ext     = BITS_WIDTH'(s) << (BITS_WIDTH - CHUNK_WIDTH);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_d     = d_q;
    assign out_b     = b_q;
    assign overflow  = ov_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            a_q     <= '0;
            nb_q    <= '0;
            d_q     <= '0;
            carry_q <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            b_q     <= 1'b0;
            ov_q    <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
            nz_q    <= 1'b0;
            z_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_q     <= a_d;
            nb_q    <= nb_d;
            d_q     <= d_d;
            carry_q <= carry_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            b_q     <= b_d;
            ov_q    <= ov_d;
`ifdef SUB_ZERO_FLAG_EN
            nz_q    <= nz_d;
            z_q     <= z_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        a_d     = a_q;
        nb_d    = nb_q;
        d_d     = d_q;
        carry_d = carry_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        b_d     = b_q;
        ov_d    = ov_q;
`ifdef SUB_ZERO_FLAG_EN
        nz_d    = nz_q;
        z_d     = z_q;
`endif
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            nb_d    = ~b;
            sa_d    = a[MSB];
            sb_d    = b[MSB];
            carry_d = 1'b1;
            count_d = '0;
            state_d = BUSY;
`ifdef SUB_ZERO_FLAG_EN
            nz_d    = 1'b0;
`endif
        end else if (state_q == BUSY) begin
            a_d     = (a_q >> CHUNK_WIDTH) | s_ext;
            nb_d    = nb_q >> CHUNK_WIDTH;
            carry_d = cout;
            count_d = count_q + 1'b1;
`ifdef SUB_ZERO_FLAG_EN
            nz_d    = nz_q | (|s);
`endif
            if (count_q == CNT_W'(N - 1)) begin
                state_d = DONE;
                d_d     = a_d;
                b_d     = ~cout;
                ov_d    = (sa_q ^ sb_q) & (s[CHUNK_WIDTH-1] ^ sa_q);
`ifdef SUB_ZERO_FLAG_EN
                z_d     = ~nz_d;
`endif
            end
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of an 8/1 and an 8/4 serial subtractor against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       in_valid [2], in_ready [2], out_valid [2], out_ready [2], out_b [2], overflow [2];
    logic [7:0] a [2], b [2], out_d [2];
`ifdef SUB_ZERO_FLAG_EN
    logic       out_zero [2];
`endif

    int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
    logic       pend [2];
    logic [7:0] ea [2], eb [2];

    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.BITS_WIDTH(8), .CHUNK_WIDTH(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_d(out_d[0]), .out_b(out_b[0]),
        .overflow(overflow[0])
`ifdef SUB_ZERO_FLAG_EN
        , .out_zero(out_zero[0])
`endif
    );

    serial_subtractor #(.BITS_WIDTH(8), .CHUNK_WIDTH(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_d(out_d[1]), .out_b(out_b[1]),
        .overflow(overflow[1])
`ifdef SUB_ZERO_FLAG_EN
        , .out_zero(out_zero[1])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: plain integer arithmetic on the operand values.
    function automatic logic [7:0] m_d(input logic [7:0] x, input logic [7:0] y);
        return 8'((int'(x) - int'(y) + 256) % 256);
    endfunction

    function automatic logic m_b(input logic [7:0] x, input logic [7:0] y);
        return int'(x) < int'(y);
    endfunction

    function automatic logic m_ov(input logic [7:0] x, input logic [7:0] y);
        int sd;
        sd = int'($signed(x)) - int'($signed(y));
        return sd < -128 || sd > 127;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid[i]) begin
                    check("result_expected", {31'b0, pend[i]}, 1);
                    check("model_d", out_d[i], m_d(ea[i], eb[i]));
                    check("model_borrow", out_b[i], m_b(ea[i], eb[i]));
                    check("model_overflow", overflow[i], m_ov(ea[i], eb[i]));
                    check("in_ready_in_done", in_ready[i], 0);
`ifdef SUB_ZERO_FLAG_EN
                    check("model_zero", out_zero[i], m_d(ea[i], eb[i]) == 8'h00);
`endif
                    if (out_ready[i]) pend[i] = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input int i, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        a[i] = x;
        b[i] = y;
        in_valid[i] = 1'b1;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", in_ready[i], 1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        acc_cyc = cyc;
        ea[i] = x;
        eb[i] = y;
        pend[i] = 1'b1;
    endtask

    // lat = index of the first edge after acceptance at which out_valid is sampled high.
    task automatic wait_valid(input int i, output int lat);
        int e = 0;
        bit hit = 0;
        lat = 0;
        while (!hit && e < 40) begin
            @(negedge clk);
            if (out_valid[i]) begin
                hit = 1;
                lat = e + 1;
            end else begin
                @(posedge clk);
                e++;
            end
        end
    endtask

    task automatic run(input int i, input logic [7:0] x, input logic [7:0] y, input logic [7:0] ed,
                       input logic eb_, input logic eov, input int elat);
        int lat;
        send(i, x, y);
        wait_valid(i, lat);
        check("latency", lat, elat);
        check("out_d", out_d[i], ed);
        check("out_b", out_b[i], eb_);
        check("overflow", overflow[i], eov);
`ifdef SUB_ZERO_FLAG_EN
        check("out_zero", out_zero[i], ed == 8'h00);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int t0;
        logic [7:0] held;
        rst = 1'b1;
        pend = '{1'b0, 1'b0};
        in_valid = '{1'b0, 1'b0};
        out_ready = '{1'b1, 1'b1};
        a = '{8'h00, 8'h00};
        b = '{8'h00, 8'h00};
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready[0], 1);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_out_d", out_d[0], 0);
        check("rst_out_b", out_b[0], 0);
        check("rst_overflow", overflow[0], 0);
        check("rst_in_ready_c4", in_ready[1], 1);
`ifdef SUB_ZERO_FLAG_EN
        check("rst_out_zero", out_zero[0], 0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        run(0, 8'h05, 8'h03, 8'h02, 0, 0, 9);
        run(0, 8'h00, 8'h01, 8'hFF, 1, 0, 9);
        run(0, 8'h80, 8'h01, 8'h7F, 0, 1, 9);
        run(0, 8'h7F, 8'hFF, 8'h80, 1, 1, 9);
        run(0, 8'h00, 8'h80, 8'h80, 1, 1, 9);
        run(0, 8'hFF, 8'hFF, 8'h00, 0, 0, 9);

        // Back-to-back with out_ready high: one result per N+2 cycles.
        send(0, 8'h33, 8'h11);
        t0 = acc_cyc;
        send(0, 8'h44, 8'h22);
        check("throughput", acc_cyc - t0, 10);
        begin
            int lat;
            wait_valid(0, lat);
            check("latency_b2b", lat, 9);
        end
        @(posedge clk); #1;

        // Backpressure: result held, in_valid pulse ignored.
        out_ready[0] = 1'b0;
        run_hold: begin
            int lat;
            send(0, 8'hA5, 8'h5A);
            wait_valid(0, lat);
            check("bp_latency", lat, 9);
            held = out_d[0];
            check("bp_out_d", held, 8'h4B);
            for (int k = 0; k < 5; k++) begin
                @(posedge clk); #1;
                if (k == 1) begin
                    a[0] = 8'h01;
                    b[0] = 8'h01;
                    in_valid[0] = 1'b1;
                end
                if (k == 2) in_valid[0] = 1'b0;
                check("bp_valid", out_valid[0], 1);
                check("bp_in_ready", in_ready[0], 0);
                check("bp_stable_d", out_d[0], 8'h4B);
                check("bp_stable_b", out_b[0], 0);
                check("bp_stable_ov", overflow[0], 1);
            end
            out_ready[0] = 1'b1;
            @(posedge clk); #1;
            check("bp_release_ready", in_ready[0], 1);
            check("bp_release_valid", out_valid[0], 0);
        end

        // Asynchronous reset on the 3rd BUSY cycle.
        send(0, 8'h77, 8'h11);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        pend[0] = 1'b0;
        #1;
        check("arst_out_valid", out_valid[0], 0);
        check("arst_in_ready", in_ready[0], 1);
        check("arst_out_d", out_d[0], 0);
        check("arst_overflow", overflow[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run(0, 8'h10, 8'h10, 8'h00, 0, 0, 9);

        // Four bits per cycle: N=2.
        run(1, 8'h5A, 8'h5A, 8'h00, 0, 0, 3);
        run(1, 8'h5B, 8'h5A, 8'h01, 0, 0, 3);
        run(1, 8'h00, 8'h01, 8'hFF, 1, 0, 3);
        run(1, 8'h80, 8'h01, 8'h7F, 0, 1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
